csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Architectural control/status register file for the LoongArch-style core. It sits directly downstream of the EX-stage privilege unit.
- It consumes that unit's csr_addr/csr_wdata/csr_wen/csr_ren requests and returns csr_rdata.
- It holds exception state (CRMD/PRMD/ESTAT/ERA/EENTRY), scratch registers and a constant timer.
- It drives the interrupt-pending and trap-target signals to the commit/fetch logic.

Parameters:
- TID_RESET, 32'h0, reset value of TID register.
- TIMER_W, 32, width of TVAL counter; InitVal field is TCFG[TIMER_W-1:2].

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- csr_addr  in  14  CSR number; low 14 bits of EX csr_addr bus
- csr_ren  in  1  read request
- csr_wen  in  1  write request
- csr_wdata  in  32  write data
- csr_wmask  in  32  bit write mask; all-ones for csrwr, rj value for csrxchg
- csr_rdata  out  32  read data
- hw_int  in  8  external hardware interrupt lines, level-sensitive
- excp_valid  in  1  exception commit pulse
- excp_ecode  in  6  exception code
- excp_pc  in  32  PC of faulting instruction
- ertn_valid  in  1  ertn commit pulse
- eentry  out  32  exception entry address (EENTRY)
- era  out  32  return address (ERA)
- plv  out  2  current privilege level (CRMD.PLV)
- int_pending  out  1  enabled interrupt pending

Behaviour:
- Reset is asynchronous on rstn=0. CRMD=32'h8 (DA=1, IE=0, PLV=0). TID=TID_RESET. All other registers are 0. All outputs are 0 except csr_rdata, which reflects the current address.
- Register map (unlisted bits read 0 and ignore writes):
  - CRMD 0x0: PLV[1:0], IE[2], DA[3].
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ECFG 0x4: LIE[12:0].
  - ESTAT 0x5: IS[1:0] software-writable; IS[9:2] hardware; IS[11] timer; Ecode[21:16]. Only IS[1:0] is CSR-writable.
  - ERA 0x6: full 32 bits.
  - EENTRY 0xC: bits [31:6] writable; [5:0] read 0.
  - SAVE0-3 0x30-0x33: full 32 bits.
  - TID 0x40: full 32 bits.
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: read-only.
  - TICLR 0x44: write-1-to-clear bit0; reads 0.
- Unimplemented address: reads 0; writes are ignored.
- Read is combinational and same-cycle.
  - csr_rdata = register at csr_addr when csr_ren|csr_wen, else 0.
  - The read always returns the pre-write value; this gives csrxchg old-value semantics.
- Write commits at posedge when csr_wen=1: new = (old & ~wmask) | (wdata & wmask), restricted to the writable bits.
- Update priority in a single cycle is excp_valid > ertn_valid > csr_wen. A lower-priority request in the same cycle is dropped entirely.
- On excp_valid:
  - PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE.
  - CRMD.PLV<=0; CRMD.IE<=0.
  - ERA<=excp_pc; ESTAT.Ecode<=excp_ecode.
- On ertn_valid: CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE.
- ESTAT.IS[9:2] <= hw_int every cycle. This is a registered sample with 1-cycle latency.
- Timer, evaluated each cycle:
  - A CSR write to TCFG with new En=1 loads TVAL<={InitVal,2'b00}. This has priority over counting that cycle.
  - Otherwise, if TCFG.En=1 and TVAL!=0: TVAL<=TVAL-1.
  - If TCFG.En=1 and TVAL==0: IS[11]<=1. If Periodic=1, TVAL reloads {InitVal,2'b00}; else TCFG.En<=0 and TVAL holds 0.
  - TICLR write with wdata&wmask bit0=1 clears IS[11]. If expiry and clear coincide, the set wins.
  - A TCFG write with En=0 stops the timer; TVAL holds.
- int_pending = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]). This is combinational from registered state.
- eentry, era and plv are direct register views.

Test Plan:
- Reset: rstn low mid-timer-count -> immediately CRMD=8, TVAL=0, int_pending=0, eentry=0. After release, a read of addr 0x0 returns 32'h8.
- csrxchg on SAVE0:
  - Setup: SAVE0=32'hFFFF0000.
  - Stimulus: csr_wen=1, wdata=32'h12345678, wmask=32'h00FF00FF.
  - Response: same-cycle rdata=32'hFFFF0000; next read gives 32'hFF340078.
- One-shot timer: write TCFG=32'h0000_0005 (InitVal=1, En=1) -> TVAL=4, then 3,2,1,0. IS[11]=1 on the cycle after TVAL==0 is seen, and En clears. Writing TICLR=1 clears IS[11].
- Periodic timer with ECFG.LIE[11]=1 and CRMD.IE=1: TCFG=32'h0B (InitVal=2, Periodic, En) -> TVAL reloads 8 after reaching 0, and int_pending rises.
- Exception/ertn:
  - Setup: CRMD=32'h7.
  - excp_valid with ecode=6'h0B, pc=32'h1C00_0040, plus simultaneous csr_wen to ERA -> ERA=32'h1C000040, PRMD=32'h7, CRMD=0, Ecode=0x0B; the CSR write is dropped.
  - Then ertn_valid -> CRMD=32'h7, plv=3.
- Write to unimplemented addr 0x7 and read-only TVAL -> no state change; read of 0x7 returns 0.

Source files
------------

// File: rtl/csr_file.sv
// Architectural CSR file: exception state, scratch registers and a constant timer.
// Reads are combinational and return the pre-write value; writes and trap updates commit at posedge.
module csr_file #(
    parameter logic [31:0] TID_RESET = 32'h0,
    parameter int          TIMER_W   = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [13:0] csr_addr,
    input  logic        csr_ren,
    input  logic        csr_wen,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] csr_wmask,
    output logic [31:0] csr_rdata,
    input  logic [7:0]  hw_int,
    input  logic        excp_valid,
    input  logic [5:0]  excp_ecode,
    input  logic [31:0] excp_pc,
    input  logic        ertn_valid,
    output logic [31:0] eentry,
    output logic [31:0] era,
    output logic [1:0]  plv,
    output logic        int_pending
);
    localparam logic [13:0] A_CRMD   = 14'h0;
    localparam logic [13:0] A_PRMD   = 14'h1;
    localparam logic [13:0] A_ECFG   = 14'h4;
    localparam logic [13:0] A_ESTAT  = 14'h5;
    localparam logic [13:0] A_ERA    = 14'h6;
    localparam logic [13:0] A_EENTRY = 14'hC;
    localparam logic [13:0] A_SAVE0  = 14'h30;
    localparam logic [13:0] A_SAVE1  = 14'h31;
    localparam logic [13:0] A_SAVE2  = 14'h32;
    localparam logic [13:0] A_SAVE3  = 14'h33;
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_TCFG   = 14'h41;
    localparam logic [13:0] A_TVAL   = 14'h42;
    localparam logic [13:0] A_TICLR  = 14'h44;

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] data,
                                            input logic [31:0] mask);
        return (old & ~mask) | (data & mask);
    endfunction

    logic [1:0]         r_crmd_plv;
    logic               r_crmd_ie;
    logic               r_crmd_da;
    logic [1:0]         r_prmd_pplv;
    logic               r_prmd_pie;
    logic [12:0]        r_ecfg_lie;
    logic [1:0]         r_is_sw;
    logic [7:0]         r_is_hw;
    logic               r_is_ti;
    logic [5:0]         r_ecode;
    logic [31:0]        r_era;
    logic [25:0]        r_eentry;
    logic [31:0]        r_save0;
    logic [31:0]        r_save1;
    logic [31:0]        r_save2;
    logic [31:0]        r_save3;
    logic [31:0]        r_tid;
    logic [TIMER_W-1:0] r_tcfg;
    logic [TIMER_W-1:0] r_tval;

    logic [12:0] w_is;
    logic [31:0] w_cur;
    logic [31:0] w_wval;
    logic        w_we;
    logic        w_tcfg_wr;
    logic        w_expire;
    logic        w_ticlr;

    assign w_is = {1'b0, r_is_ti, 1'b0, r_is_hw, r_is_sw};

    always_comb begin
        w_cur = 32'h0;
        case (csr_addr)
            A_CRMD:   w_cur = {28'h0, r_crmd_da, r_crmd_ie, r_crmd_plv};
            A_PRMD:   w_cur = {29'h0, r_prmd_pie, r_prmd_pplv};
            A_ECFG:   w_cur = {19'h0, r_ecfg_lie};
            A_ESTAT:  w_cur = {10'h0, r_ecode, 3'h0, w_is};
            A_ERA:    w_cur = r_era;
            A_EENTRY: w_cur = {r_eentry, 6'h0};
            A_SAVE0:  w_cur = r_save0;
            A_SAVE1:  w_cur = r_save1;
            A_SAVE2:  w_cur = r_save2;
            A_SAVE3:  w_cur = r_save3;
            A_TID:    w_cur = r_tid;
            A_TCFG:   w_cur = 32'(r_tcfg);
            A_TVAL:   w_cur = 32'(r_tval);
            default:  w_cur = 32'h0;
        endcase
    end

    assign csr_rdata = (csr_ren | csr_wen) ? w_cur : 32'h0;

    // A CSR write that loses to a trap or ertn in the same cycle has no side effects at all.
    assign w_we      = csr_wen & ~excp_valid & ~ertn_valid;
    assign w_wval    = f_merge(w_cur, csr_wdata, csr_wmask);
    assign w_tcfg_wr = w_we && (csr_addr == A_TCFG);
    assign w_expire  = !w_tcfg_wr && r_tcfg[0] && (r_tval == '0);
    assign w_ticlr   = w_we && (csr_addr == A_TICLR) && csr_wdata[0] && csr_wmask[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_crmd_plv  <= 2'd0;
            r_crmd_ie   <= 1'b0;
            r_crmd_da   <= 1'b1;
            r_prmd_pplv <= 2'd0;
            r_prmd_pie  <= 1'b0;
            r_ecfg_lie  <= 13'h0;
            r_is_sw     <= 2'd0;
            r_is_hw     <= 8'h0;
            r_is_ti     <= 1'b0;
            r_ecode     <= 6'h0;
            r_era       <= 32'h0;
            r_eentry    <= 26'h0;
            r_save0     <= 32'h0;
            r_save1     <= 32'h0;
            r_save2     <= 32'h0;
            r_save3     <= 32'h0;
            r_tid       <= TID_RESET;
            r_tcfg      <= '0;
            r_tval      <= '0;
        end else begin
            r_is_hw <= hw_int;
            if (excp_valid) begin
                r_prmd_pplv <= r_crmd_plv;
                r_prmd_pie  <= r_crmd_ie;
                r_crmd_plv  <= 2'd0;
                r_crmd_ie   <= 1'b0;
                r_era       <= excp_pc;
                r_ecode     <= excp_ecode;
            end else if (ertn_valid) begin
                r_crmd_plv <= r_prmd_pplv;
                r_crmd_ie  <= r_prmd_pie;
            end else if (w_we) begin
                case (csr_addr)
                    A_CRMD:   {r_crmd_da, r_crmd_ie, r_crmd_plv} <= w_wval[3:0];
                    A_PRMD:   {r_prmd_pie, r_prmd_pplv} <= w_wval[2:0];
                    A_ECFG:   r_ecfg_lie <= w_wval[12:0];
                    A_ESTAT:  r_is_sw <= w_wval[1:0];
                    A_ERA:    r_era <= w_wval;
                    A_EENTRY: r_eentry <= w_wval[31:6];
                    A_SAVE0:  r_save0 <= w_wval;
                    A_SAVE1:  r_save1 <= w_wval;
                    A_SAVE2:  r_save2 <= w_wval;
                    A_SAVE3:  r_save3 <= w_wval;
                    A_TID:    r_tid <= w_wval;
                    default:  ;
                endcase
            end

            // TCFG writes own the timer for that cycle: load on En=1, freeze on En=0.
            if (w_tcfg_wr) begin
                r_tcfg <= w_wval[TIMER_W-1:0];
                if (w_wval[0]) r_tval <= {w_wval[TIMER_W-1:2], 2'b00};
            end else if (r_tcfg[0]) begin
                if (r_tval != '0) r_tval <= r_tval - TIMER_W'(1);
                else if (r_tcfg[1]) r_tval <= {r_tcfg[TIMER_W-1:2], 2'b00};
                else r_tcfg[0] <= 1'b0;
            end

            if (w_expire) r_is_ti <= 1'b1;
            else if (w_ticlr) r_is_ti <= 1'b0;
        end
    end

    assign eentry      = {r_eentry, 6'h0};
    assign era         = r_era;
    assign plv         = r_crmd_plv;
    assign int_pending = r_crmd_ie & |(w_is & r_ecfg_lie);
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a vector table of single-cycle CSR accesses plus
// hand-written timer, trap/ertn, interrupt and asynchronous-reset sequences.
module tb_csr_file;
    logic        clk;
    logic        rstn;
    logic [13:0] csr_addr;
    logic        csr_ren;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic [31:0] csr_rdata;
    logic [7:0]  hw_int;
    logic        excp_valid;
    logic [5:0]  excp_ecode;
    logic [31:0] excp_pc;
    logic        ertn_valid;
    logic [31:0] eentry;
    logic [31:0] era;
    logic [1:0]  plv;
    logic        int_pending;

    int n_tests = 0;
    int n_fail  = 0;

    csr_file #(.TID_RESET(32'h0), .TIMER_W(32)) dut (
        .clk(clk), .rstn(rstn), .csr_addr(csr_addr), .csr_ren(csr_ren), .csr_wen(csr_wen),
        .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .csr_rdata(csr_rdata), .hw_int(hw_int),
        .excp_valid(excp_valid), .excp_ecode(excp_ecode), .excp_pc(excp_pc),
        .ertn_valid(ertn_valid), .eentry(eentry), .era(era), .plv(plv),
        .int_pending(int_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [13:0] addr;
        logic        ren;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[28];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        csr_addr  = a;
        csr_ren   = 1'b0;
        csr_wen   = 1'b1;
        csr_wdata = d;
        csr_wmask = m;
        tick();
        csr_wen   = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [13:0] a, input logic [31:0] exp);
        csr_addr = a;
        csr_ren  = 1'b1;
        csr_wen  = 1'b0;
        #1;
        chk(nm, csr_rdata, exp);
    endtask

    initial begin
        vecs[0]  = '{"rd_crmd_rst",  14'h0,  1, 0, 32'h0,        32'h0,        32'h0000_0008};
        vecs[1]  = '{"idle_rdata0",  14'h30, 0, 0, 32'h0,        32'h0,        32'h0};
        vecs[2]  = '{"wr_save0",     14'h30, 0, 1, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0};
        vecs[3]  = '{"xchg_save0",   14'h30, 0, 1, 32'h12345678, 32'h00FF00FF, 32'hFFFF0000};
        vecs[4]  = '{"rd_save0",     14'h30, 1, 0, 32'h0,        32'h0,        32'hFF340078};
        vecs[5]  = '{"wr_save3",     14'h33, 0, 1, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h0};
        vecs[6]  = '{"rd_save3",     14'h33, 1, 0, 32'h0,        32'h0,        32'hA5A5A5A5};
        vecs[7]  = '{"wr_eentry",    14'hC,  0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        vecs[8]  = '{"rd_eentry",    14'hC,  1, 0, 32'h0,        32'h0,        32'hFFFFFFC0};
        vecs[9]  = '{"wr_unimpl",    14'h7,  0, 1, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0};
        vecs[10] = '{"rd_unimpl",    14'h7,  1, 0, 32'h0,        32'h0,        32'h0};
        vecs[11] = '{"wr_tval_ro",   14'h42, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        vecs[12] = '{"rd_tval_ro",   14'h42, 1, 0, 32'h0,        32'h0,        32'h0};
        vecs[13] = '{"wr_ecfg",      14'h4,  0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        vecs[14] = '{"rd_ecfg",      14'h4,  1, 0, 32'h0,        32'h0,        32'h00001FFF};
        vecs[15] = '{"wr_estat",     14'h5,  0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        vecs[16] = '{"rd_estat_sw",  14'h5,  1, 0, 32'h0,        32'h0,        32'h00000003};
        vecs[17] = '{"xchg_estat",   14'h5,  0, 1, 32'h0,        32'h00000001, 32'h00000003};
        vecs[18] = '{"rd_estat_b1",  14'h5,  1, 0, 32'h0,        32'h0,        32'h00000002};
        vecs[19] = '{"clr_estat",    14'h5,  0, 1, 32'h0,        32'hFFFFFFFF, 32'h00000002};
        vecs[20] = '{"rd_estat_0",   14'h5,  1, 0, 32'h0,        32'h0,        32'h0};
        vecs[21] = '{"rd_tid_rst",   14'h40, 1, 0, 32'h0,        32'h0,        32'h0};
        vecs[22] = '{"wr_tid",       14'h40, 0, 1, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h0};
        vecs[23] = '{"rd_tid",       14'h40, 1, 0, 32'h0,        32'h0,        32'hCAFEF00D};
        vecs[24] = '{"wr_prmd",      14'h1,  0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        vecs[25] = '{"rd_prmd",      14'h1,  1, 0, 32'h0,        32'h0,        32'h00000007};
        vecs[26] = '{"rd_ticlr",     14'h44, 1, 0, 32'h0,        32'h0,        32'h0};
        vecs[27] = '{"rd_crmd_keep", 14'h0,  1, 0, 32'h0,        32'h0,        32'h00000008};

        rstn = 1'b0; csr_addr = 14'h0; csr_ren = 1'b1; csr_wen = 1'b0;
        csr_wdata = 32'h0; csr_wmask = 32'h0; hw_int = 8'h0;
        excp_valid = 1'b0; excp_ecode = 6'h0; excp_pc = 32'h0; ertn_valid = 1'b0;
        tick(); tick();
        chk("rst_rdata_crmd", csr_rdata, 32'h8);
        chk("rst_outputs", {eentry, era, 29'h0, plv, int_pending}, 96'h0);
        rstn = 1'b1;

        for (int i = 0; i < 28; i++) begin
            csr_addr  = vecs[i].addr;
            csr_ren   = vecs[i].ren;
            csr_wen   = vecs[i].wen;
            csr_wdata = vecs[i].wdata;
            csr_wmask = vecs[i].wmask;
            #1;
            chk(vecs[i].name, csr_rdata, vecs[i].exp_rdata);
            tick();
        end
        csr_wen = 1'b0;
        chk("eentry_out", eentry, 32'hFFFFFFC0);

        // one-shot timer
        wr(14'h41, 32'h5, 32'hFFFFFFFF);
        for (int v = 4; v >= 0; v--) begin
            rd_chk($sformatf("oneshot_tval_%0d", v), 14'h42, 32'(v));
            if (v == 0) rd_chk("oneshot_is11_pre", 14'h5, 32'h0);
            if (v != 0) tick();
        end
        tick();
        rd_chk("oneshot_is11_set", 14'h5, 32'h0000_0800);
        rd_chk("oneshot_en_clr", 14'h41, 32'h4);
        rd_chk("oneshot_tval_hold", 14'h42, 32'h0);
        chk("oneshot_noint_ie0", {31'h0, int_pending}, 32'h0);
        tick();
        rd_chk("oneshot_tval_hold2", 14'h42, 32'h0);
        wr(14'h44, 32'h1, 32'hFFFFFFFF);
        rd_chk("ticlr_clears", 14'h5, 32'h0);

        // periodic timer with interrupt enabled
        wr(14'h0, 32'h4, 32'hFFFFFFFF);
        wr(14'h41, 32'h0B, 32'hFFFFFFFF);
        rd_chk("per_tval_load", 14'h42, 32'h8);
        for (int v = 7; v >= 0; v--) begin
            tick();
            rd_chk($sformatf("per_tval_%0d", v), 14'h42, 32'(v));
        end
        chk("per_int_pre", {31'h0, int_pending}, 32'h0);
        tick();
        rd_chk("per_tval_reload", 14'h42, 32'h8);
        rd_chk("per_is11", 14'h5, 32'h0000_0800);
        chk("per_int_rise", {31'h0, int_pending}, 32'h1);
        wr(14'h41, 32'h0, 32'hFFFFFFFF);
        rd_chk("stop_tval_hold", 14'h42, 32'h8);
        tick();
        rd_chk("stop_tval_hold2", 14'h42, 32'h8);
        wr(14'h44, 32'h1, 32'h1);
        chk("per_int_clr", {31'h0, int_pending}, 32'h0);

        // trap entry with a competing CSR write, then ertn with one
        wr(14'h0, 32'h7, 32'hFFFFFFFF);
        chk("plv_before_excp", {30'h0, plv}, 32'h3);
        csr_addr = 14'h6; csr_wen = 1'b1; csr_wdata = 32'h55555555; csr_wmask = 32'hFFFFFFFF;
        excp_valid = 1'b1; excp_ecode = 6'h0B; excp_pc = 32'h1C00_0040;
        tick();
        excp_valid = 1'b0; csr_wen = 1'b0;
        chk("excp_era", era, 32'h1C00_0040);
        chk("excp_plv", {30'h0, plv}, 32'h0);
        rd_chk("excp_prmd", 14'h1, 32'h7);
        rd_chk("excp_crmd", 14'h0, 32'h0);
        rd_chk("excp_estat", 14'h5, 32'h000B_0000);
        csr_addr = 14'h1; csr_wen = 1'b1; csr_wdata = 32'h0; csr_wmask = 32'hFFFFFFFF;
        ertn_valid = 1'b1;
        tick();
        ertn_valid = 1'b0; csr_wen = 1'b0;
        rd_chk("ertn_crmd", 14'h0, 32'h7);
        rd_chk("ertn_prmd_kept", 14'h1, 32'h7);
        chk("ertn_plv", {30'h0, plv}, 32'h3);

        // hardware interrupt line, one-cycle sampled
        hw_int = 8'h01;
        #1;
        chk("hwint_latency", {31'h0, int_pending}, 32'h0);
        tick();
        hw_int = 8'h00;
        rd_chk("hwint_estat", 14'h5, 32'h000B_0004);
        chk("hwint_pending", {31'h0, int_pending}, 32'h1);
        tick();
        chk("hwint_drop", {31'h0, int_pending}, 32'h0);

        // asynchronous reset in the middle of a count
        wr(14'h41, 32'h101, 32'hFFFFFFFF);
        tick(); tick();
        rd_chk("pre_rst_tval", 14'h42, 32'hFE);
        wr(14'h5, 32'h1, 32'h3);
        chk("pre_rst_int", {31'h0, int_pending}, 32'h1);
        @(negedge clk);
        rstn = 1'b0;
        rd_chk("async_rst_crmd", 14'h0, 32'h8);
        rd_chk("async_rst_tval", 14'h42, 32'h0);
        chk("async_rst_int", {31'h0, int_pending}, 32'h0);
        chk("async_rst_eentry", eentry, 32'h0);
        chk("async_rst_era_plv", {era[29:0], plv}, 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        rd_chk("post_rst_crmd", 14'h0, 32'h8);
        rd_chk("post_rst_tval_idle", 14'h42, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
